// File: rtl/onehot_pulse_decoder_pkg.sv
// onehot_pulse_decoder_pkg: shared state encoding and index-to-one-hot helper
package onehot_pulse_decoder_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;
  localparam int MAX_IDX_W = 8;
  function automatic logic [2**MAX_IDX_W-1:0] idx_to_onehot(input logic [MAX_IDX_W-1:0] idx);
    return {{(2**MAX_IDX_W-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/onehot_pulse_decoder_if.sv
// onehot_pulse_decoder_if: index handshake plus decoded one-hot strobe outputs
interface onehot_pulse_decoder_if #(parameter int IDX_W = 3);
  logic in_valid;
  logic in_ready;
  logic [IDX_W-1:0] in_idx;
  logic [2**IDX_W-1:0] out_onehot;
  logic out_active;
  logic done;
  modport master(output in_valid, in_idx, input in_ready, out_onehot, out_active, done);
  modport slave(input in_valid, in_idx, output in_ready, out_onehot, out_active, done);
endinterface

// File: rtl/onehot_pulse_decoder_hold_counter.sv
// onehot_hold_counter: loadable down-counter that parks at zero and flags it
module onehot_hold_counter #(parameter int CNT_W = 8) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);
  assign zero = cnt == '0;
  // load has priority; otherwise count down until zero and stay there
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= load ? load_val : zero ? cnt : cnt - CNT_W'(1);
endmodule

// File: rtl/onehot_pulse_decoder.sv
// onehot_pulse_decoder: holds a decoded one-hot line for HOLD cycles per accepted index
module onehot_pulse_decoder
  import onehot_pulse_decoder_pkg::*;
#(
  parameter int IDX_W = 3,
  parameter int HOLD  = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  onehot_pulse_decoder_if.slave bus
);
  localparam int OUT_W = 2**IDX_W;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD - 1);
  state_t state;
  logic pend_full;
  logic [IDX_W-1:0] pend_idx;
  logic [CNT_W-1:0] cnt;
  logic accept, zero, last, load;
  assign bus.in_ready = !pend_full;
  assign accept = bus.in_valid && !pend_full;
  assign last = state == ST_IDLE || zero;
  assign load = last && (pend_full || accept);
  assign bus.out_active = state == ST_ACTIVE;
  onehot_hold_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .load(load), .load_val(RELOAD), .cnt(cnt), .zero(zero)
  );
  // on a slot boundary load pending (else bypass, else go idle); mid-hold park a new index as pending
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      bus.out_onehot <= '0;
      bus.done <= 1'b0;
      pend_full <= 1'b0;
      pend_idx <= '0;
    end else if (last) begin
      state <= load ? ST_ACTIVE : ST_IDLE;
      bus.out_onehot <= load ? OUT_W'(idx_to_onehot(MAX_IDX_W'(pend_full ? pend_idx : bus.in_idx))) : '0;
      bus.done <= load && (HOLD == 1);
      pend_full <= 1'b0;
    end else begin
      bus.done <= cnt == CNT_W'(1);
      if (accept) begin
        pend_full <= 1'b1;
        pend_idx <= bus.in_idx;
      end
    end
endmodule
